demux_1to4_stream: RTL and testbench
====================================

# demux_1to4_stream

Registered 1-to-4 stream demultiplexer: the distribution-side counterpart of the cascaded 4-to-1 mux. It accepts one data word per valid/ready transfer on a single input port and routes it, by a per-transfer select, into one of four output channels. Each output channel holds a one-entry buffer, so a stalled consumer on one channel blocks only transfers addressed to that channel. The block sits between a shared producer and four independent consumers.

## Interface
- data_width, default 4: width of each data word.
- select_width, default 2: width of the channel select; the channel count is fixed at 4, so only 2 is legal.
- clk_in  input  1  sole clock; all logic on rising edge.
- reset_n_in  input  1  reset, synchronous and active-low.
- s_valid_in  input  1  input word valid.
- s_ready_out  output  1  block can accept the input word this cycle.
- s_data_in  input  data_width  input word.
- sel_in  input  select_width  destination channel for the current input word; sampled with s_data_in.
- m_valid_out  output  4  per-channel output valid.
- m_ready_in  input  4  per-channel consumer ready.
- m_data_out  output  4*data_width  channel k occupies bits [k*data_width +: data_width].
- xfer_count_out  output  4*8  per-channel saturating count of words delivered; channel k occupies bits [k*8 +: 8].

## Operation
- Per channel k: buffer register buf_data[k] and flag full[k].
- Input transfer occurs when s_valid_in && s_ready_out.
- s_ready_out = !full[sel_in] || m_ready_in[sel_in]. It is combinational, depends on sel_in and m_ready_in, and does not depend on s_valid_in.
- m_valid_out[k] = full[k]; m_data_out slice k = buf_data[k]; both come directly from registers.
- Output transfer on channel k occurs when full[k] && m_ready_in[k].
- Per-channel update each cycle:
  - Input transfer to k and no output transfer on k: full[k] becomes 1, data loaded.
  - Output transfer on k and no input transfer to k: full[k] becomes 0, data held.
  - Input transfer to k and output transfer on k in the same cycle: full[k] stays 1 and the new data is loaded (pass-through at full throughput).
  - Otherwise: hold.
- Channels other than sel_in are unaffected by input transfers. Any number of channels may drain in the same cycle.
- xfer_count[k] increments on each output transfer on k. It saturates at 255 and never wraps.
- s_data_in and sel_in are ignored when s_valid_in is 0.

## Timing
- Reset (reset_n_in low at a rising edge): all full[k] = 0, all buf_data = 0, all xfer_count = 0.
  - Resulting outputs: m_valid_out = 4'b0000, m_data_out = 0, xfer_count_out = 0.
  - s_ready_out = 1 while in reset and after it, because all channels are empty.
- Reset in the middle of traffic discards all buffered words. Words accepted in the cycle reset is applied are lost.
- Latency: a word accepted at edge N is visible on its channel's m_valid_out/m_data_out after edge N, i.e. 1 cycle.
- Throughput: 1 word per cycle, sustained, while the selected consumer holds ready high.
- Backpressure: with full[k] = 1 and m_ready_in[k] = 0, s_ready_out = 0 whenever sel_in = k.
  - The producer must hold s_valid_in, s_data_in and sel_in stable until the transfer.
  - The producer may change sel_in only after the transfer; it is not required to drop valid to do so.
- The counter updates at the same edge as the output transfer.

## Structure
- Package demux_pkg:
  - NUM_CH = 4.
  - CNT_W = 8.
  - CNT_MAX = 8'hFF.
  - typedef logic [CNT_W-1:0] cnt_t.
- Sub-module demux_chan_buf, instantiated 4 times via a generate loop. It holds the one-entry buffer, the full flag and the saturating counter for one channel.
  - Ports: clk_in, reset_n_in, load_in, data_in, ready_in, valid_out, data_out, count_out.
  - Its can-accept term (!full || ready_in) is exported and muxed by sel_in in the top level to form s_ready_out.
- The top level holds the select decode, the load-enable generation and the ready mux.

## Test plan
- Reset then idle: hold reset_n_in low for 2 cycles, then release. Required: m_valid_out = 0000, xfer_count_out = 0, s_ready_out = 1.
- Routing: send 0xA to sel 0, 0x5 to sel 1, 0x3 to sel 2 and 0xC to sel 3 on consecutive cycles, with all m_ready_in = 0.
  - Each channel shows its word one cycle after acceptance.
  - After the last edge m_valid_out = 1111, with all other channels unchanged.
- Backpressure: channel 2 is full with m_ready_in[2] = 0, and sel_in = 2 with s_valid_in = 1.
  - Required: s_ready_out = 0 for 5 cycles and data is held.
  - Then raise m_ready_in[2]: in that cycle the old word drains and the new word loads, so m_valid_out[2] stays 1.
- Isolation: channel 0 is stalled and full. Stream 4 words to channel 1 with m_ready_in[1] = 1.
  - Required: s_ready_out = 1 throughout, 4 deliveries on channel 1, and channel 0 data unchanged.
- Saturation: make 260 transfers to channel 3. Required: xfer_count_out slice 3 = 255, other slices = 0.
- Mid-stream reset: assert reset_n_in while all channels are full. Required: at the next edge m_valid_out = 0000 and all counts = 0.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// demux_pkg - channel count, counter width and types for demux_1to4_stream  (rev 1.0)
// ============================================================================
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage
`default_nettype wire

// File: rtl/demux_chan_buf.sv
`default_nettype none
// ============================================================================
// demux_chan_buf - one-entry output buffer with saturating delivery counter  (rev 1.0)
// ============================================================================
module demux_chan_buf
  import demux_pkg::*;
#(
  parameter int data_width = 4
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic                  load_in,
  input  logic [data_width-1:0] data_in,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [data_width-1:0] data_out,
  output cnt_t                  count_out,
  output logic                  can_accept_out
);

  logic                  full;
  logic [data_width-1:0] buf_data;
  cnt_t                  xfer_count;
  logic                  drain;

  assign drain          = full && ready_in;
  assign can_accept_out = !full || ready_in;

  // A load in the same cycle as a drain keeps the entry full (pass-through).
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      full       <= 1'b0;
      buf_data   <= '0;
      xfer_count <= '0;
    end else begin
      if (load_in) begin
        full     <= 1'b1;
        buf_data <= data_in;
      end else if (drain) begin
        full <= 1'b0;
      end
      if (drain && (xfer_count != CNT_MAX)) begin
        xfer_count <= xfer_count + cnt_t'(1);
      end
    end
  end

  assign valid_out = full;
  assign data_out  = buf_data;
  assign count_out = xfer_count;

endmodule
`default_nettype wire

// File: rtl/demux_1to4_stream.sv
`default_nettype none
// ============================================================================
// demux_1to4_stream - registered 1-to-4 valid/ready demux, one buffer per channel  (rev 1.0)
// ============================================================================
module demux_1to4_stream
  import demux_pkg::*;
#(
  parameter int data_width   = 4,
  parameter int select_width = 2
) (
  input  logic                         clk_in,
  input  logic                         reset_n_in,
  input  logic                         s_valid_in,
  output logic                         s_ready_out,
  input  logic [data_width-1:0]        s_data_in,
  input  logic [select_width-1:0]      sel_in,
  output logic [NUM_CH-1:0]            m_valid_out,
  input  logic [NUM_CH-1:0]            m_ready_in,
  output logic [NUM_CH*data_width-1:0] m_data_out,
  output logic [NUM_CH*CNT_W-1:0]      xfer_count_out
);

  logic [NUM_CH-1:0] sel_hit;
  logic [NUM_CH-1:0] can_accept;
  logic [NUM_CH-1:0] load;
  logic              accept;

  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_hit[k] = (sel_in == select_width'(k));
    end
  end

  // Only the addressed channel gates the producer; others may stall freely.
  assign s_ready_out = |(can_accept & sel_hit);
  assign accept      = s_valid_in && s_ready_out;
  assign load        = {NUM_CH{accept}} & sel_hit;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
      demux_chan_buf #(
        .data_width(data_width)
      ) u_chan (
        .clk_in         (clk_in),
        .reset_n_in     (reset_n_in),
        .load_in        (load[k]),
        .data_in        (s_data_in),
        .ready_in       (m_ready_in[k]),
        .valid_out      (m_valid_out[k]),
        .data_out       (m_data_out[k*data_width +: data_width]),
        .count_out      (xfer_count_out[k*CNT_W +: CNT_W]),
        .can_accept_out (can_accept[k])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_demux_1to4_stream.sv
`default_nettype none
// ============================================================================
// tb_demux_1to4_stream - directed vector bench for demux_1to4_stream  (rev 1.0)
// ============================================================================
module tb_demux_1to4_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_data;
  logic [1:0]  sel;
  logic [3:0]  m_valid;
  logic [3:0]  m_ready;
  logic [15:0] m_data;
  logic [31:0] counts;

  int check_cnt = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  demux_1to4_stream #(
    .data_width  (4),
    .select_width(2)
  ) dut (
    .clk_in        (clk),
    .reset_n_in    (rst_n),
    .s_valid_in    (s_valid),
    .s_ready_out   (s_ready),
    .s_data_in     (s_data),
    .sel_in        (sel),
    .m_valid_out   (m_valid),
    .m_ready_in    (m_ready),
    .m_data_out    (m_data),
    .xfer_count_out(counts)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  sel;
    logic [3:0]  data;
    logic [3:0]  mready;
    logic        exp_sready;
    logic [3:0]  exp_mvalid;
    logic [15:0] exp_mdata;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] mr);
    s_valid = v;
    sel     = s;
    s_data  = d;
    m_ready = mr;
  endtask

  initial begin
    // Routing, backpressure on ch2, valid-low idle, then isolation streaming to ch1.
    vecs[0]  = '{1'b1, 2'd0, 4'hA, 4'b0000, 1'b1, 4'b0001, 16'h000A, 32'h0000_0000};
    vecs[1]  = '{1'b1, 2'd1, 4'h5, 4'b0000, 1'b1, 4'b0011, 16'h005A, 32'h0000_0000};
    vecs[2]  = '{1'b1, 2'd2, 4'h3, 4'b0000, 1'b1, 4'b0111, 16'h035A, 32'h0000_0000};
    vecs[3]  = '{1'b1, 2'd3, 4'hC, 4'b0000, 1'b1, 4'b1111, 16'hC35A, 32'h0000_0000};
    for (int i = 4; i < 9; i++)
      vecs[i] = '{1'b1, 2'd2, 4'h7, 4'b0000, 1'b0, 4'b1111, 16'hC35A, 32'h0000_0000};
    vecs[9]  = '{1'b1, 2'd2, 4'h7, 4'b0100, 1'b1, 4'b1111, 16'hC75A, 32'h0001_0000};
    vecs[10] = '{1'b0, 2'd0, 4'hF, 4'b0000, 1'b0, 4'b1111, 16'hC75A, 32'h0001_0000};
    vecs[11] = '{1'b1, 2'd1, 4'h1, 4'b0010, 1'b1, 4'b1111, 16'hC71A, 32'h0001_0100};
    vecs[12] = '{1'b1, 2'd1, 4'h2, 4'b0010, 1'b1, 4'b1111, 16'hC72A, 32'h0001_0200};
    vecs[13] = '{1'b1, 2'd1, 4'h3, 4'b0010, 1'b1, 4'b1111, 16'hC73A, 32'h0001_0300};
    vecs[14] = '{1'b1, 2'd1, 4'h4, 4'b0010, 1'b1, 4'b1111, 16'hC74A, 32'h0001_0400};
    vecs[15] = '{1'b0, 2'd1, 4'h0, 4'b0010, 1'b1, 4'b1101, 16'hC74A, 32'h0001_0500};

    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'h0, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_mvalid", {28'd0, m_valid}, 32'h0);
    check("reset_count",  counts, 32'h0);
    check("reset_mdata",  {16'd0, m_data}, 32'h0);
    check("reset_sready", {31'd0, s_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_mvalid", {28'd0, m_valid}, 32'h0);
    check("idle_sready", {31'd0, s_ready}, 32'h1);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].mready);
      #1;
      check($sformatf("vec%0d_sready", i), {31'd0, s_ready}, {31'd0, vecs[i].exp_sready});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_mvalid", i), {28'd0, m_valid}, {28'd0, vecs[i].exp_mvalid});
      check($sformatf("vec%0d_mdata", i),  {16'd0, m_data},  {16'd0, vecs[i].exp_mdata});
      check($sformatf("vec%0d_count", i),  counts, vecs[i].exp_cnt);
    end

    // Saturation: clean slate, then 260 deliveries on ch3.
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'h0, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 2'd3, 4'(i), 4'b1000);
      @(posedge clk);
      #1;
      if (i == 254) check("sat_count_254", counts, 32'hFE00_0000);
      if (i == 255) check("sat_count_255", counts, 32'hFF00_0000);
      @(negedge clk);
    end
    drive(1'b0, 2'd3, 4'h0, 4'b1000);
    @(posedge clk);
    #1;
    check("sat_count_final", counts, 32'hFF00_0000);
    check("sat_mvalid",      {28'd0, m_valid}, 32'h0);
    check("sat_lastdata",    {28'd0, m_data[15:12]}, 32'h3);

    // Mid-stream reset with all channels full and a word accepted at the reset edge.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 2'(k), 4'(k + 8), 4'b0000);
    end
    @(posedge clk);
    #1;
    check("fill_mvalid", {28'd0, m_valid}, 32'hF);
    check("fill_mdata",  {16'd0, m_data}, 32'hBA98);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 2'd0, 4'h6, 4'b0001);
    #1;
    check("midrst_sready_pre", {31'd0, s_ready}, 32'h1);
    @(posedge clk);
    #1;
    check("midrst_mvalid", {28'd0, m_valid}, 32'h0);
    check("midrst_count",  counts, 32'h0);
    check("midrst_mdata",  {16'd0, m_data}, 32'h0);
    check("midrst_sready", {31'd0, s_ready}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
    $finish;
  end

endmodule
`default_nettype wire
